// File: rtl/lfsr_uart_tx_if.sv
// Byte handshake between the LFSR core (master) and the UART serializer (slave).
interface lfsr_uart_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/lfsr_uart_tx.sv
// 8N1 UART transmitter fed by a valid/ready byte handshake; streams LFSR words
// out on a single serial pin, LSB first.
module lfsr_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  lfsr_uart_tx_if.slave   up,
  output logic            tx,
  output logic            busy,
  output logic            frame_done
);

  localparam logic [7:0] BaudLast = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] baud_q, baud_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       tx_q, tx_d;
  logic       frame_done_q, frame_done_d;
  logic       bit_end;

  assign bit_end     = (baud_q == BaudLast);
  assign up.in_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign tx          = tx_q;
  assign frame_done  = frame_done_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;

    unique case (state_q)
      StIdle: begin
        if (up.in_valid) begin
          shift_d = up.in_data;
          baud_d  = 8'd0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          baud_d    = 8'd0;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          baud_d  = 8'd0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          baud_d  = 8'd0;
          state_d = StIdle;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // tx and frame_done are registered from the next state so they line up with it.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    frame_done_d = (state_d == StStop) && (baud_d == BaudLast);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      shift_q      <= 8'd0;
      baud_q       <= 8'd0;
      bit_idx_q    <= 3'd0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      baud_q       <= baud_d;
      bit_idx_q    <= bit_idx_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
